// File: rtl/dm_dualport_sync.sv
// ============================================================================
// dm_dualport_sync : dual-port data memory (A = byte-masked R/W, B = read-only
// fetch) with req/ready handshake, fixed-latency responses and a clear engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_dualport_sync #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 65536,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int MASK_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [MASK_WIDTH-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int RESP_WIDTH = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic                  a_acc, b_acc;
  logic                  a_in_range, b_in_range;
  logic                  a_wr_en;
  logic [DATA_WIDTH-1:0] a_word, b_word;

  // Response records are {valid, err, data}.
  logic [RESP_WIDTH-1:0] a_s1_q, a_s1_d, b_s1_q, b_s1_d;
  logic [RESP_WIDTH-1:0] a_out, b_out;

  assign idle       = (state_q == ST_IDLE);
  assign a_ready    = idle && !clr_req;
  assign b_ready    = idle && !clr_req;
  assign busy       = (state_q == ST_CLEAR);
  assign a_acc      = a_req && a_ready;
  assign b_acc      = b_req && b_ready;
  assign a_in_range = ({1'b0, a_addr} < C_DEPTH);
  assign b_in_range = ({1'b0, b_addr} < C_DEPTH);
  assign a_wr_en    = a_acc && a_we && a_in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == C_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear and port A writes never coincide: requests are refused while clearing.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else if (a_wr_en) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (a_be[i]) begin
          mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Port B forwards same-edge port A write bytes (write-first).
  always_comb begin
    a_word = (a_in_range && !a_we) ? mem[a_addr] : '0;
    b_word = b_in_range ? mem[b_addr] : '0;
    if (a_wr_en && (a_addr == b_addr)) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (a_be[i]) begin
          b_word[i*8 +: 8] = a_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    a_s1_d = {a_acc, a_acc && !a_in_range, a_acc ? a_word : {DATA_WIDTH{1'b0}}};
    b_s1_d = {b_acc, b_acc && !b_in_range, b_acc ? b_word : {DATA_WIDTH{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_s1_q <= '0;
      b_s1_q <= '0;
    end else begin
      a_s1_q <= a_s1_d;
      b_s1_q <= b_s1_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [RESP_WIDTH-1:0] a_s2_q, a_s2_d, b_s2_q, b_s2_d;

      always_comb begin
        a_s2_d = a_s1_q;
        b_s2_d = b_s1_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_s2_q <= '0;
          b_s2_q <= '0;
        end else begin
          a_s2_q <= a_s2_d;
          b_s2_q <= b_s2_d;
        end
      end

      assign a_out = a_s2_q;
      assign b_out = b_s2_q;
    end else begin : g_lat1
      assign a_out = a_s1_q;
      assign b_out = b_s1_q;
    end
  endgenerate

  assign {a_rvalid, a_err, a_rdata} = a_out;
  assign {b_rvalid, b_err, b_rdata} = b_out;

endmodule

`default_nettype wire

// File: tb/tb_dm_dualport_sync.sv
// ============================================================================
// tb_dm_dualport_sync : directed checks on two instances
// (DEPTH=16/latency 1 and DEPTH=12/latency 2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dm_dualport_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // instance 1: DEPTH 16, READ_LATENCY 1
  logic        a1_req, a1_we, a1_ready, a1_rvalid, a1_err;
  logic [3:0]  a1_be, a1_addr;
  logic [31:0] a1_wdata, a1_rdata;
  logic        b1_req, b1_ready, b1_rvalid, b1_err;
  logic [3:0]  b1_addr;
  logic [31:0] b1_rdata;
  logic        clr1, busy1;

  // instance 2: DEPTH 12, READ_LATENCY 2
  logic        a2_req, a2_we, a2_ready, a2_rvalid, a2_err;
  logic [3:0]  a2_be, a2_addr;
  logic [31:0] a2_wdata, a2_rdata;
  logic        b2_req, b2_ready, b2_rvalid, b2_err;
  logic [3:0]  b2_addr;
  logic [31:0] b2_rdata;
  logic        clr2, busy2;

  dm_dualport_sync #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(a1_req), .a_we(a1_we), .a_be(a1_be), .a_addr(a1_addr), .a_wdata(a1_wdata),
    .a_ready(a1_ready), .a_rvalid(a1_rvalid), .a_rdata(a1_rdata), .a_err(a1_err),
    .b_req(b1_req), .b_addr(b1_addr), .b_ready(b1_ready), .b_rvalid(b1_rvalid),
    .b_rdata(b1_rdata), .b_err(b1_err), .clr_req(clr1), .busy(busy1)
  );

  dm_dualport_sync #(.DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .a_req(a2_req), .a_we(a2_we), .a_be(a2_be), .a_addr(a2_addr), .a_wdata(a2_wdata),
    .a_ready(a2_ready), .a_rvalid(a2_rvalid), .a_rdata(a2_rdata), .a_err(a2_err),
    .b_req(b2_req), .b_addr(b2_addr), .b_ready(b2_ready), .b_rvalid(b2_rvalid),
    .b_rdata(b2_rdata), .b_err(b2_err), .clr_req(clr2), .busy(busy2)
  );

  // sel: 0 = inst1 A, 1 = inst1 B, 2 = inst2 A, 3 = inst2 B
  int          sel = 0;
  logic        mon_v, mon_e;
  logic [31:0] mon_d;

  always_comb begin
    mon_v = 1'b0;
    mon_e = 1'b0;
    mon_d = 32'h0;
    case (sel)
      0: begin mon_v = a1_rvalid; mon_e = a1_err; mon_d = a1_rdata; end
      1: begin mon_v = b1_rvalid; mon_e = b1_err; mon_d = b1_rdata; end
      2: begin mon_v = a2_rvalid; mon_e = a2_err; mon_d = a2_rdata; end
      default: begin mon_v = b2_rvalid; mon_e = b2_err; mon_d = b2_rdata; end
    endcase
  end

  typedef struct {
    int          s;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic req, input logic we, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] wd);
    case (s)
      0: begin a1_req = req; a1_we = we; a1_be = be; a1_addr = addr; a1_wdata = wd; end
      1: begin b1_req = req; b1_addr = addr; end
      2: begin a2_req = req; a2_we = we; a2_be = be; a2_addr = addr; a2_wdata = wd; end
      default: begin b2_req = req; b2_addr = addr; end
    endcase
  endtask

  task automatic issue(input string tag, input vec_t v);
    int k;
    int lat;
    lat = (v.s >= 2) ? 2 : 1;
    @(negedge clk);
    sel = v.s;
    drive(v.s, 1'b1, v.we, v.be, v.addr, v.wd);
    @(negedge clk);
    drive(v.s, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    k = 1;
    while (!mon_v && k < 6) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " rdata"}, mon_d, v.exp_d);
    check({tag, " err"}, {31'h0, mon_e}, {31'h0, v.exp_e});
    @(negedge clk);
    check({tag, " one-cycle rvalid"}, {31'h0, mon_v}, 32'h0);
  endtask

  function automatic vec_t mk(int s, logic we, logic [3:0] be, logic [3:0] addr,
                              logic [31:0] wd, logic [31:0] ed, logic ee);
    vec_t v;
    v.s = s; v.we = we; v.be = be; v.addr = addr; v.wd = wd; v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int n2;
    a1_req = 0; a1_we = 0; a1_be = 0; a1_addr = 0; a1_wdata = 0; b1_req = 0; b1_addr = 0; clr1 = 0;
    a2_req = 0; a2_we = 0; a2_be = 0; a2_addr = 0; a2_wdata = 0; b2_req = 0; b2_addr = 0; clr2 = 0;

    tbl[0]  = mk(0, 0, 4'h0, 4'd5,  32'h0,        32'h00000000, 0);
    tbl[1]  = mk(0, 1, 4'hF, 4'd3,  32'hDEADBEEF, 32'h00000000, 0);
    tbl[2]  = mk(0, 1, 4'h5, 4'd3,  32'h11223344, 32'h00000000, 0);
    tbl[3]  = mk(0, 0, 4'h0, 4'd3,  32'h0,        32'hDE22BE44, 0);
    tbl[4]  = mk(1, 0, 4'h0, 4'd3,  32'h0,        32'hDE22BE44, 0);
    tbl[5]  = mk(0, 1, 4'hF, 4'd7,  32'h12345678, 32'h00000000, 0);
    tbl[6]  = mk(0, 0, 4'h0, 4'd7,  32'h0,        32'h12345678, 0);
    tbl[7]  = mk(0, 1, 4'h1, 4'd0,  32'h000000FF, 32'h00000000, 0);
    tbl[8]  = mk(0, 1, 4'h2, 4'd0,  32'h0000AB00, 32'h00000000, 0);
    tbl[9]  = mk(0, 0, 4'h0, 4'd0,  32'h0,        32'h0000ABFF, 0);
    tbl[10] = mk(0, 1, 4'hF, 4'd15, 32'hCAFEF00D, 32'h00000000, 0);
    tbl[11] = mk(1, 0, 4'h0, 4'd15, 32'h0,        32'hCAFEF00D, 0);
    tbl[12] = mk(0, 1, 4'h0, 4'd1,  32'hFFFFFFFF, 32'h00000000, 0);
    tbl[13] = mk(0, 0, 4'h0, 4'd1,  32'h0,        32'h00000000, 0);
    tbl[14] = mk(2, 0, 4'h0, 4'd13, 32'h0,        32'h00000000, 1);
    tbl[15] = mk(2, 1, 4'hF, 4'd11, 32'h0BADCAFE, 32'h00000000, 0);
    tbl[16] = mk(2, 1, 4'hF, 4'd13, 32'hFFFFFFFF, 32'h00000000, 1);
    tbl[17] = mk(2, 0, 4'h0, 4'd13, 32'h0,        32'h00000000, 1);
    tbl[18] = mk(3, 0, 4'h0, 4'd13, 32'h0,        32'h00000000, 1);
    tbl[19] = mk(2, 0, 4'h0, 4'd11, 32'h0,        32'h0BADCAFE, 0);
    tbl[20] = mk(3, 0, 4'h0, 4'd1,  32'h0,        32'h00000000, 0);
    tbl[21] = mk(3, 0, 4'h0, 4'd5,  32'h0,        32'h00000000, 0);
    tbl[22] = mk(2, 0, 4'h0, 4'd10, 32'h0,        32'h00000000, 0);
    tbl[23] = mk(2, 1, 4'hF, 4'd0,  32'h00000010, 32'h00000000, 0);
    tbl[24] = mk(2, 1, 4'hF, 4'd1,  32'h00000011, 32'h00000000, 0);
    tbl[25] = mk(2, 1, 4'hF, 4'd2,  32'h00000012, 32'h00000000, 0);
    tbl[26] = mk(2, 1, 4'hF, 4'd3,  32'h00000013, 32'h00000000, 0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("reset busy", {31'h0, busy1}, 32'h1);
    check("reset a_ready", {31'h0, a1_ready}, 32'h0);
    check("reset b_ready", {31'h0, b1_ready}, 32'h0);
    check("reset a_rvalid", {31'h0, a1_rvalid}, 32'h0);
    check("reset b_rvalid", {31'h0, b1_rvalid}, 32'h0);
    check("reset a_rdata", a1_rdata, 32'h0);
    check("reset a_err", {31'h0, a1_err}, 32'h0);

    // power-up clear length
    rst = 1'b1;
    n1 = 0;
    while (busy1 && n1 < 40) begin
      @(negedge clk);
      n1++;
    end
    check("initial clear cycles", 32'(n1), 32'd16);
    check("a_ready after clear", {31'h0, a1_ready}, 32'h1);
    check("b_ready after clear", {31'h0, b1_ready}, 32'h1);

    for (int i = 0; i < 27; i++) begin
      issue($sformatf("vec%0d", i), tbl[i]);
    end

    // same-edge A write and B read of addr 7 (old 0x12345678)
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'h3, 4'd7, 32'hAABBCCDD);
    drive(1, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    check("wf a_rvalid", {31'h0, a1_rvalid}, 32'h1);
    check("wf a_rdata", a1_rdata, 32'h0);
    check("wf b_rvalid", {31'h0, b1_rvalid}, 32'h1);
    check("wf b_rdata merged", b1_rdata, 32'h1234CCDD);
    issue("wf readback", mk(0, 0, 4'h0, 4'd7, 32'h0, 32'h1234CCDD, 0));

    // simultaneous A and B read of the same word
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    check("dual read a", a1_rvalid ? a1_rdata : 32'hFFFFFFFF, 32'hDE22BE44);
    check("dual read b", b1_rvalid ? b1_rdata : 32'hFFFFFFFF, 32'hDE22BE44);

    // latency-2 back-to-back B reads of 0..3
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("b2b rvalid c%0d", c), {31'h0, b2_rvalid}, (c >= 2 && c <= 5) ? 32'h1 : 32'h0);
      if (c >= 2 && c <= 5) check($sformatf("b2b rdata c%0d", c), b2_rdata, 32'h10 + 32'(c - 2));
      if (c < 4) drive(3, 1'b1, 1'b0, 4'h0, 4'(c), 32'h0);
      else drive(3, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    end

    // clear with a read in flight (instance 2)
    issue("pre-clear write", mk(2, 1, 4'hF, 4'd2, 32'h00000055, 32'h0, 0));
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    check("in-flight rvalid", {31'h0, a2_rvalid}, 32'h1);
    check("in-flight rdata", a2_rdata, 32'h55);
    check("clear a_ready", {31'h0, a2_ready}, 32'h0);
    n2 = 0;
    while (busy2 && n2 < 40) begin
      @(negedge clk);
      n2++;
    end
    check("clr_req clear cycles", 32'(n2), 32'd12);
    issue("post-clear addr2", mk(2, 0, 4'h0, 4'd2, 32'h0, 32'h0, 0));
    issue("post-clear addr0", mk(2, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0));

    // reset during clear (inst1) and during a read (inst2)
    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    drive(2, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("pre-reset a_rvalid", {31'h0, a2_rvalid}, 32'h1);
    check("pre-reset busy", {31'h0, busy1}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check("async reset a_rvalid", {31'h0, a2_rvalid}, 32'h0);
    check("async reset busy2", {31'h0, busy2}, 32'h1);
    check("async reset a_ready", {31'h0, a1_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    n1 = 0;
    n2 = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy1) n1++;
      if (busy2) n2++;
      @(negedge clk);
    end
    check("restart clear cycles inst1", 32'(n1), 32'd16);
    check("restart clear cycles inst2", 32'(n2), 32'd12);
    issue("after restart addr3", mk(0, 0, 4'h0, 4'd3, 32'h0, 32'h0, 0));
    issue("after restart addr15", mk(1, 0, 4'h0, 4'd15, 32'h0, 32'h0, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
